iic_cmd_arbiter: RTL and testbench
==================================

Name: iic_cmd_arbiter

Overview:
- Shares a single IIC bus between C_REQ_NUM requesters by sequencing one iic_send (write) engine and one iic_recv (read) engine.
- Each requester issues one-byte register read or write commands.
- The block picks a requester round-robin, drives the chosen engine's level enable until its done pulse, and returns read data and a completion or timeout pulse.
- Sits between firmware-side register clients and the two bit-level IIC engines.

Parameters:
- C_REQ_NUM, 2, number of requesters (2..8)
- C_TIMEOUT_CYC, 200000, maximum cycles an engine enable may stay high before abort
- C_GAP_CYC, 250, idle cycles between transactions (bus free time; 5 us at 50 MHz)

Ports:
- I_clk  in  1  system clock (50 MHz)
- I_rst_n  in  1  asynchronous active-low reset
- I_req  in  C_REQ_NUM  per-requester request; held high until its O_ack or O_timeout
- I_req_rw  in  C_REQ_NUM  1 = read, 0 = write
- I_req_dev_addr  in  C_REQ_NUM*7  7-bit device addresses, requester k at [7k+6:7k]
- I_req_word_addr  in  C_REQ_NUM*8  word addresses, requester k at [8k+7:8k]
- I_req_wdata  in  C_REQ_NUM*8  write data, requester k at [8k+7:8k]
- O_grant  out  C_REQ_NUM  one-hot; identifies the requester being served
- O_ack  out  C_REQ_NUM  one-cycle completion pulse to the served requester
- O_timeout  out  C_REQ_NUM  one-cycle abort pulse to the served requester
- O_rdata  out  8  last successful read byte
- O_busy  out  1  high from grant through the end of the gap
- O_iic_send_en  out  1  write engine enable (level)
- O_iic_recv_en  out  1  read engine enable (level)
- O_dev_addr  out  7  latched device address
- O_word_addr  out  8  latched word address
- O_write_data  out  8  latched write data
- I_send_done  in  1  write engine done pulse
- I_recv_done  in  1  read engine done pulse
- I_read_data  in  8  read engine data, valid with I_recv_done

Behaviour:
- Reset (async): all outputs 0, state IDLE, round-robin pointer = C_REQ_NUM-1 (requester 0 has first priority), timeout and gap counters 0.
- Reset asserted mid-transaction drops both enables immediately. No ack or timeout pulse is produced.
- All outputs are registered.

State machine:
- IDLE: when any I_req is set, select the first set bit searching from pointer+1 with wrap-around. Register O_grant, latch address/data/rw, set O_busy, go to RUN. Grant appears 1 cycle after request is sampled.
- RUN: drive O_iic_recv_en if rw = 1, otherwise O_iic_send_en. The enable rises 1 cycle after grant. Exactly one enable is high at a time. The timeout counter increments each cycle.
  - On the selected engine's done pulse: clear the enable; if read, capture I_read_data into O_rdata; pulse O_ack for the granted bit; go to GAP.
  - Done from the non-selected engine is ignored.
  - When the counter reaches C_TIMEOUT_CYC-1 without done: clear the enable, pulse O_timeout, leave O_rdata unchanged, go to GAP.
  - Done and timeout on the same cycle: done wins.
- GAP: clear O_grant, set pointer = served index, count C_GAP_CYC cycles, then go to IDLE and clear O_busy. Requests are not sampled in GAP.
- A requester dropping I_req during RUN does not abort; the transaction completes and ack is still pulsed.
- I_req_* fields are sampled only at grant; later changes have no effect.
- A single requester re-requesting continuously is served back-to-back, separated by the gap. With multiple requesters active, service strictly rotates.
- Counters are sized by $clog2 of their parameter. No wrap-around occurs, because each counter clears on leaving its state.

Decomposition:
- Package iic_ctrl_pkg: state encodings (IDLE, RUN, GAP), default timeout and gap constants, and the dev/word/data width constants (7/8/8) shared with the engines.
- Sub-module iic_rr_arbiter: combinational round-robin selector. Inputs are the request vector and pointer; outputs are the one-hot grant and binary index.

Test Plan (C_TIMEOUT_CYC=1000, C_GAP_CYC=4, behavioural engine models):
- Requester 0 write, dev 0x50, word 0x12, data 0xA5 -> O_dev_addr=0x50, O_word_addr=0x12, O_write_data=0xA5; O_iic_send_en high 2 cycles after I_req; ack[0] pulses 1 cycle after I_send_done; recv_en never high.
- Requester 1 read, engine returns 0x3C -> O_rdata=0x3C when ack[1] pulses; send_en stays 0 throughout.
- Both requesters held continuously for 4 transactions -> grant order 0,1,0,1; at least 4 idle cycles between enables.
- Engine never raises done -> enable drops after 1000 cycles; timeout pulses; O_rdata keeps its previous value; next request is served normally.
- Reset pulsed mid-RUN -> enables, grant, and busy go to 0 asynchronously; no ack; after release, requester 0 is granted first.
- I_send_done pulses during a read transaction -> ignored; read completes on I_recv_done only.

Source files
------------

// File: rtl/iic_ctrl_pkg.sv
// Shared definitions for the IIC command arbiter and the bit-level engines it drives.
package iic_ctrl_pkg;

  localparam int DEV_W  = 7;
  localparam int WORD_W = 8;
  localparam int DATA_W = 8;

  localparam int DEF_TIMEOUT_CYC = 200000;
  localparam int DEF_GAP_CYC     = 250;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Bits needed for a counter/index covering 0..n-1, never narrower than 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iic_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, with wrap-around.
module iic_rr_arbiter
  import iic_ctrl_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = cnt_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int            pos;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      cand = IW'(pos);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/iic_cmd_arbiter.sv
// Round-robin sequencer sharing one IIC bus (send + recv engines) between C_REQ_NUM
// register clients; one byte per transaction, with timeout abort and a bus-free gap.
module iic_cmd_arbiter
  import iic_ctrl_pkg::*;
#(
  parameter int C_REQ_NUM     = 2,
  parameter int C_TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int C_GAP_CYC     = DEF_GAP_CYC
) (
  input  logic                        I_clk,
  input  logic                        I_rst_n,
  input  logic [C_REQ_NUM-1:0]        I_req,
  input  logic [C_REQ_NUM-1:0]        I_req_rw,
  input  logic [C_REQ_NUM*DEV_W-1:0]  I_req_dev_addr,
  input  logic [C_REQ_NUM*WORD_W-1:0] I_req_word_addr,
  input  logic [C_REQ_NUM*DATA_W-1:0] I_req_wdata,
  output logic [C_REQ_NUM-1:0]        O_grant,
  output logic [C_REQ_NUM-1:0]        O_ack,
  output logic [C_REQ_NUM-1:0]        O_timeout,
  output logic [DATA_W-1:0]           O_rdata,
  output logic                        O_busy,
  output logic                        O_iic_send_en,
  output logic                        O_iic_recv_en,
  output logic [DEV_W-1:0]            O_dev_addr,
  output logic [WORD_W-1:0]           O_word_addr,
  output logic [DATA_W-1:0]           O_write_data,
  input  logic                        I_send_done,
  input  logic                        I_recv_done,
  input  logic [DATA_W-1:0]           I_read_data
);

  localparam int IW = cnt_w(C_REQ_NUM);
  localparam int TW = cnt_w(C_TIMEOUT_CYC);
  localparam int GW = cnt_w(C_GAP_CYC);

  state_t                 state;
  logic [IW-1:0]          ptr;
  logic [IW-1:0]          idx;
  logic                   rw;
  logic [TW-1:0]          tcnt;
  logic [GW-1:0]          gcnt;
  logic [C_REQ_NUM-1:0]   sel_grant;
  logic [IW-1:0]          sel_idx;
  logic                   en_any;
  logic                   done_sel;

  iic_rr_arbiter #(.N(C_REQ_NUM), .IW(IW)) u_rr (
    .req   (I_req),
    .ptr   (ptr),
    .grant (sel_grant),
    .idx   (sel_idx)
  );

  assign en_any   = O_iic_send_en | O_iic_recv_en;
  // Only the engine this transaction enabled may end it.
  assign done_sel = rw ? I_recv_done : I_send_done;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state         <= IDLE;
      ptr           <= IW'(C_REQ_NUM - 1);
      idx           <= '0;
      rw            <= 1'b0;
      tcnt          <= '0;
      gcnt          <= '0;
      O_grant       <= '0;
      O_ack         <= '0;
      O_timeout     <= '0;
      O_rdata       <= '0;
      O_busy        <= 1'b0;
      O_iic_send_en <= 1'b0;
      O_iic_recv_en <= 1'b0;
      O_dev_addr    <= '0;
      O_word_addr   <= '0;
      O_write_data  <= '0;
    end else begin
      O_ack     <= '0;
      O_timeout <= '0;
      case (state)
        IDLE: begin
          if (|I_req) begin
            O_grant      <= sel_grant;
            idx          <= sel_idx;
            rw           <= I_req_rw[sel_idx];
            O_dev_addr   <= I_req_dev_addr[sel_idx*DEV_W +: DEV_W];
            O_word_addr  <= I_req_word_addr[sel_idx*WORD_W +: WORD_W];
            O_write_data <= I_req_wdata[sel_idx*DATA_W +: DATA_W];
            O_busy       <= 1'b1;
            tcnt         <= '0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (!en_any) begin
            // First RUN cycle: raise the enable one cycle after the grant.
            O_iic_recv_en <= rw;
            O_iic_send_en <= ~rw;
          end else if (done_sel) begin
            O_iic_send_en <= 1'b0;
            O_iic_recv_en <= 1'b0;
            if (rw) O_rdata <= I_read_data;
            O_ack   <= O_grant;
            O_grant <= '0;
            ptr     <= idx;
            tcnt    <= '0;
            gcnt    <= '0;
            state   <= GAP;
          end else if (tcnt == TW'(C_TIMEOUT_CYC - 1)) begin
            O_iic_send_en <= 1'b0;
            O_iic_recv_en <= 1'b0;
            O_timeout <= O_grant;
            O_grant   <= '0;
            ptr       <= idx;
            tcnt      <= '0;
            gcnt      <= '0;
            state     <= GAP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: begin
          if (gcnt == GW'(C_GAP_CYC - 1)) begin
            gcnt   <= '0;
            O_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_cmd_arbiter.sv
// Directed + randomized bench for iic_cmd_arbiter with behavioural engines and a
// transaction-level round-robin model.
module tb_iic_cmd_arbiter;

  localparam int N = 3;
  localparam int T = 1000;
  localparam int G = 4;

  logic           clk, rst_n;
  logic [N-1:0]   req, req_rw;
  logic [N*7-1:0] dev_bus;
  logic [N*8-1:0] word_bus, wd_bus;
  logic [N-1:0]   grant, ack, timeout;
  logic [7:0]     rdata, word_o, wd_o, read_data;
  logic [6:0]     dev_o;
  logic           busy, send_en, recv_en, send_done, recv_done;

  bit       rw_a   [N];
  bit [6:0] dev_a  [N];
  bit [7:0] word_a [N];
  bit [7:0] wd_a   [N];

  int         cmp_cnt = 0;
  int         err_cnt = 0;
  int         rp;
  logic [7:0] last_rd;

  always_comb begin
    req_rw = '0; dev_bus = '0; word_bus = '0; wd_bus = '0;
    for (int k = 0; k < N; k++) begin
      req_rw[k]         = rw_a[k];
      dev_bus[7*k +: 7] = dev_a[k];
      word_bus[8*k +: 8] = word_a[k];
      wd_bus[8*k +: 8]  = wd_a[k];
    end
  end

  iic_cmd_arbiter #(.C_REQ_NUM(N), .C_TIMEOUT_CYC(T), .C_GAP_CYC(G)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_req(req), .I_req_rw(req_rw),
    .I_req_dev_addr(dev_bus), .I_req_word_addr(word_bus), .I_req_wdata(wd_bus),
    .O_grant(grant), .O_ack(ack), .O_timeout(timeout), .O_rdata(rdata), .O_busy(busy),
    .O_iic_send_en(send_en), .O_iic_recv_en(recv_en), .O_dev_addr(dev_o),
    .O_word_addr(word_o), .O_write_data(wd_o), .I_send_done(send_done),
    .I_recv_done(recv_done), .I_read_data(read_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Served requester = first active one after the last served, cyclically.
  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic scramble();
    for (int k = 0; k < N; k++) begin
      rw_a[k] = 1'($urandom); dev_a[k] = 7'($urandom);
      word_a[k] = 8'($urandom); wd_a[k] = 8'($urandom);
    end
  endtask

  // Runs one transaction starting from an idle bus with req already driven.
  task automatic do_txn(input int lat, input bit tmo, input bit wrong, input bit keep,
                        input bit early);
    int ei, n, g;
    bit erw, ok;
    logic [6:0] edev;
    logic [7:0] eword, ewd, rd;
    ei = rr_pick(req, rp);
    n = 0;
    do begin @(negedge clk); n++; end while (grant == '0 && n < 20);
    erw = rw_a[ei]; edev = dev_a[ei]; eword = word_a[ei]; ewd = wd_a[ei];
    chk("grant", grant, 32'(1 << ei));
    chk("busy_at_grant", busy, 1);
    chk("latch_at_grant", {dev_o, word_o, wd_o}, {edev, eword, ewd});
    chk("en_at_grant", {send_en, recv_en}, 0);
    scramble();
    if (early) req[ei] = 1'b0;
    @(negedge clk);
    chk("en_rise", {send_en, recv_en}, erw ? 2'b01 : 2'b10);
    if (tmo) begin
      n = 1;
      while (n < T + 20) begin
        @(negedge clk);
        if (!(send_en | recv_en)) break;
        n++;
      end
      chk("tmo_len", n, T);
      chk("tmo_pulse", timeout, 32'(1 << ei));
      chk("tmo_no_ack", ack, 0);
    end else begin
      ok = 1'b1;
      for (int c = 1; c < lat; c++) begin
        if (wrong && c == 1) begin
          if (erw) send_done = 1'b1; else recv_done = 1'b1;
        end
        @(negedge clk);
        send_done = 1'b0; recv_done = 1'b0;
        if ({send_en, recv_en} != (erw ? 2'b01 : 2'b10) || ack != '0) ok = 1'b0;
      end
      rd = 8'($urandom);
      read_data = rd;
      if (erw) recv_done = 1'b1; else send_done = 1'b1;
      @(negedge clk);
      send_done = 1'b0; recv_done = 1'b0; read_data = 8'($urandom);
      if (erw) last_rd = rd;
      chk("en_hold", ok, 1);
      chk("ack", ack, 32'(1 << ei));
      chk("ack_no_tmo", timeout, 0);
      chk("en_fall", {send_en, recv_en}, 0);
    end
    chk("rdata", rdata, last_rd);
    chk("latch_stable", {dev_o, word_o, wd_o}, {edev, eword, ewd});
    rp = ei;
    if (!keep) req[ei] = 1'b0;
    g = 0; ok = 1'b1;
    while (busy && g < 4 * G + 10) begin
      if (grant != '0 || send_en || recv_en) ok = 1'b0;
      g++;
      @(negedge clk);
    end
    chk("gap_len", g, G);
    chk("gap_quiet", ok, 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = '0; send_done = 1'b0; recv_done = 1'b0; read_data = '0;
    for (int k = 0; k < N; k++) begin rw_a[k] = 0; dev_a[k] = 0; word_a[k] = 0; wd_a[k] = 0; end
    rp = N - 1; last_rd = '0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {grant, ack, timeout, busy, send_en, recv_en}, 0);
    chk("rst_data", {rdata, dev_o, word_o, wd_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Requester 0 write.
    rw_a[0] = 0; dev_a[0] = 7'h50; word_a[0] = 8'h12; wd_a[0] = 8'hA5; req = 3'b001;
    do_txn(5, 0, 0, 0, 0);
    // Requester 1 read with a stray send_done in the middle.
    rw_a[1] = 1; dev_a[1] = 7'h21; word_a[1] = 8'h40; req = 3'b010;
    do_txn(4, 0, 1, 0, 0);
    // Both held continuously: alternating service.
    req = 3'b011;
    for (int i = 0; i < 4; i++) do_txn(2 + i, 0, 0, (i < 3), 0);
    req = '0;
    @(negedge clk);
    // Engine never answers a read, then a normal write from requester 0.
    rw_a[1] = 1; req = 3'b010;
    do_txn(1, 1, 0, 0, 0);
    rw_a[0] = 0; req = 3'b001;
    do_txn(3, 0, 0, 0, 0);

    // Reset in the middle of a requester-2 write.
    rw_a[2] = 0; req = 3'b100;
    n = 0;
    do begin @(negedge clk); n++; end while (!send_en && n < 20);
    chk("pre_rst_en", send_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {grant, busy, send_en, recv_en}, 0);
    @(negedge clk);
    chk("rst_no_ack", {ack, timeout}, 0);
    rst_n = 1'b1; rp = N - 1; last_rd = '0;
    req = 3'b011;
    do_txn(2, 0, 0, 0, 0);
    do_txn(2, 0, 0, 0, 0);
    req = '0;

    // Randomized traffic.
    for (int i = 0; i < 25; i++) begin
      int lat;
      bit keep, early;
      if (req == '0 || $urandom_range(0, 1) == 1) req = req | 3'($urandom_range(1, 7));
      lat   = $urandom_range(1, 6);
      keep  = 1'($urandom_range(0, 1));
      early = !keep && ($urandom_range(0, 3) == 0);
      do_txn(lat, 0, (lat >= 2) && ($urandom_range(0, 1) == 1), keep, early);
    end
    req = '0;
    repeat (3) @(negedge clk);
    chk("final_idle", {busy, grant, send_en, recv_en}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
